// File: rtl/tone_generator.sv
// tone_generator
//   Picks the highest-priority held key from the keyboard bitmap, maps it to a
//   note and drives a square wave on audio. After every key lifts, the last
//   note keeps sounding for RELEASE_CYCLES clocks, then the block goes silent.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   alpha_table  key bitmap: bits 0-6 Q..U (octave 6), 7-13 A..J (octave 5),
//                14-20 Z..M (octave 4); lowest set bit has priority
//   mute         forces audio low; FSM and counters keep running
//   audio        registered square-wave output
//   note_idx     index of the sounding note, 0 when idle
//   playing      high in PLAY or RELEASE
module tone_generator #(
    parameter int CLK_HZ         = 100000000,
    parameter int RELEASE_CYCLES = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [20:0] alpha_table,
    input  logic        mute,
    output logic        audio,
    output logic [4:0]  note_idx,
    output logic        playing
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

    // Octave-4 half-period counts are quoted for a 100 MHz clock; rescale them
    // for other clock rates at elaboration time.
    function automatic logic [17:0] scale_count(input longint base);
        return 18'((base * longint'(CLK_HZ)) / 64'sd100000000);
    endfunction

    localparam logic [17:0] HC_C = scale_count(64'sd191113);
    localparam logic [17:0] HC_D = scale_count(64'sd170262);
    localparam logic [17:0] HC_E = scale_count(64'sd151686);
    localparam logic [17:0] HC_F = scale_count(64'sd143172);
    localparam logic [17:0] HC_G = scale_count(64'sd127551);
    localparam logic [17:0] HC_A = scale_count(64'sd113636);
    localparam logic [17:0] HC_B = scale_count(64'sd101239);

    // Half-period count for a key index: degree picks the base, row picks the octave shift.
    function automatic logic [17:0] half_of(input logic [4:0] idx);
        logic [4:0]  deg;
        logic [1:0]  sh;
        logic [17:0] base;
        if (idx < 5'd7) begin
            deg = idx;
            sh  = 2'd2;
        end else if (idx < 5'd14) begin
            deg = idx - 5'd7;
            sh  = 2'd1;
        end else begin
            deg = idx - 5'd14;
            sh  = 2'd0;
        end
        case (deg)
            5'd0:    base = HC_C;
            5'd1:    base = HC_D;
            5'd2:    base = HC_E;
            5'd3:    base = HC_F;
            5'd4:    base = HC_G;
            5'd5:    base = HC_A;
            5'd6:    base = HC_B;
            default: base = HC_C;
        endcase
        return base >> sh;
    endfunction

    state_t         state_q, state_d;
    logic [20:0]    key_q;
    logic [4:0]     note_q, note_d;
    logic [17:0]    half_q, half_d;
    logic [RW-1:0]  rel_q, rel_d;
    logic           tone_q, tone_d;
    logic           audio_q, audio_d;
    logic           playing_q, playing_d;

    logic           sel_valid_s;
    logic [4:0]     sel_idx_s;
    logic [17:0]    half_last_s;

    // Priority encoder: lowest set bit wins, so the scan runs from the top down.
    always_comb begin
        sel_valid_s = |key_q;
        sel_idx_s   = 5'd0;
        for (int i = 20; i >= 0; i--) begin
            if (key_q[i]) begin
                sel_idx_s = 5'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    assign half_last_s = half_of(note_q) - 18'd1;

    // Next-state, note selection, tone counter and release counter.
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        rel_d   = rel_q;
        // Default: the tone keeps running on the current note.
        if (half_q == half_last_s) begin
            half_d = 18'd0;
            tone_d = ~tone_q;
        end else begin
            half_d = half_q + 18'd1;
            tone_d = tone_q;
        end

        case (state_q)
            ST_IDLE: begin
                half_d = 18'd0;
                tone_d = 1'b0;
                rel_d  = '0;
                if (sel_valid_s) begin
                    note_d  = sel_idx_s;
                    state_d = ST_PLAY;
                end else begin
                    note_d  = 5'd0;
                end
            end
            ST_PLAY, ST_RELEASE: begin
                if (sel_valid_s) begin
                    state_d = ST_PLAY;
                    // A different note restarts its phase low so no runt pulse leaks through.
                    if (sel_idx_s != note_q) begin
                        note_d = sel_idx_s;
                        half_d = 18'd0;
                        tone_d = 1'b0;
                    end else begin
                        note_d = note_q;
                    end
                end else if (state_q == ST_PLAY) begin
                    rel_d   = '0;
                    state_d = ST_RELEASE;
                end else if (rel_q == REL_LAST) begin
                    state_d = ST_IDLE;
                    note_d  = 5'd0;
                    half_d  = 18'd0;
                    tone_d  = 1'b0;
                    rel_d   = '0;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                note_d  = 5'd0;
                half_d  = 18'd0;
                tone_d  = 1'b0;
                rel_d   = '0;
            end
        endcase

        audio_d   = tone_q & ~mute;
        // Derived from the next state so playing lines up with state_q.
        playing_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q     <= 21'd0;
            state_q   <= ST_IDLE;
            note_q    <= 5'd0;
            half_q    <= 18'd0;
            rel_q     <= '0;
            tone_q    <= 1'b0;
            audio_q   <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            key_q     <= alpha_table;
            state_q   <= state_d;
            note_q    <= note_d;
            half_q    <= half_d;
            rel_q     <= rel_d;
            tone_q    <= tone_d;
            audio_q   <= audio_d;
            playing_q <= playing_d;
        end
    end

    assign audio    = audio_q;
    assign note_idx = note_q;
    assign playing  = playing_q;

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
Downstream consumer of the keyboard block's 21-bit alpha_table key bitmap. Selects one held key by fixed priority, maps it to a musical note and drives a square-wave audio output to the board buzzer/audio pin. Holds the last note for a programmable release time after all keys lift, then falls silent.

Parameters:
CLK_HZ, 100000000, system clock frequency. Note table values below are for this default.
RELEASE_CYCLES, 10000000, cycles the tone persists after all keys release (100 ms at default). Minimum 1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
alpha_table  input  21  key bitmap from keyboard. Bits 0-6 Q..U, 7-13 A..J, 14-20 Z..M.
mute  input  1  1 forces audio low; the FSM and counters keep running
audio  output  1  square-wave tone, registered
note_idx  output  5  index (0-20) of the note currently sounding; 0 when idle
playing  output  1  1 in PLAY or RELEASE

Behaviour:
- Reset (rst=0, async): key_q=0, state=IDLE, note_idx=0, half_cnt=0, rel_cnt=0, tone=0, audio=0, playing=0.
- Input stage: alpha_table registered into key_q each clk.
- Priority encoder (combinational on key_q):
  - sel_valid = |key_q.
  - sel_idx = lowest set bit index, so the high row (Q..U) wins over A..J, which wins over Z..M.
- Note map: row = idx/7, degree = idx%7 (C D E F G A B).
  - Z..M = octave 4, A..J = octave 5, Q..U = octave 6.
- Half-period counts, octave 4, for degrees C..B: 191113, 170262, 151686, 143172, 127551, 113636, 101239.
  - Octave 5 = octave-4 count >> 1.
  - Octave 6 = octave-4 count >> 2.
  - Counter width 18 bits.
- Tone counter:
  - In PLAY or RELEASE, half_cnt increments each cycle.
  - When half_cnt == HALF-1: tone toggles and half_cnt returns to 0.
- audio <= tone & ~mute, registered.
- FSM states: IDLE, PLAY, RELEASE.
  - IDLE: tone=0, half_cnt=0. If sel_valid: note_idx<=sel_idx, go to PLAY.
  - PLAY, sel_valid && sel_idx!=note_idx: note_idx<=sel_idx, half_cnt<=0, tone<=0 (phase restart, no runt pulse carried over).
  - PLAY, sel_valid && sel_idx==note_idx: continue.
  - PLAY, !sel_valid: rel_cnt<=0, go to RELEASE.
  - RELEASE: keeps the held note toggling; rel_cnt increments.
    - sel_valid with the same idx: back to PLAY, phase continues.
    - sel_valid with a different idx: back to PLAY with phase restart, as above.
    - rel_cnt==RELEASE_CYCLES-1 with !sel_valid: go to IDLE, tone<=0, half_cnt<=0, note_idx<=0.
    - If sel_valid and release expiry coincide, key press wins: go to PLAY.
- Latency: alpha_table change sampled at edge n → key_q at n+1 → state/note_idx update at n+2 → audio reflects the first tone edge one cycle after the tone toggle.
- Multiple keys: only the highest-priority key sounds. Releasing it while others are still held switches immediately to the next-priority key, with no RELEASE phase.
- rst asserted mid-tone: immediate silence, all state cleared. After deassert, the block waits for a fresh key in IDLE.

Test Plan:
- Reset: hold rst=0 with alpha_table=21'h1FFFFF → audio=0, playing=0, note_idx=0 throughout.
- Single key A (bit 7 → C5, half=95556): assert → playing=1 and note_idx=7 two cycles later. audio toggles every 95556 cycles, period 191112.
- Priority: set bits 20 and 12 together → note_idx=12 (A5, half=56818). Clear bit 12 → note_idx=20 (B4, half=101239) within 2 cycles, phase restarted with audio low, playing stays 1.
- Release (RELEASE_CYCLES=1000): press bit 5 (A6, half=28409), then clear all → tone continues 1000 cycles, then audio=0, playing=0, note_idx=0. Re-press at release cycle 500 → back to PLAY, same phase continues.
- Mute: during a playing tone set mute=1 → audio=0 the next cycle while note_idx and playing are unchanged. Clear mute → audio resumes in phase with the internal tone.
- Async reset mid-tone: drop rst between clock edges → audio=0 and playing=0 immediately, without waiting for a clock edge.
